acc_drain_requant: RTL and testbench

- Reads the 32-bit accumulators of one MAC row once a tile finishes, then clears that row.
- Requantizes each lane to signed int8 using a per-tile multiplier, right shift and round-half-up.
- Emits the int8 results on a valid/ready stream, one lane per beat.
- Sits between the systolic array row and the output writeback buffer.

---
 rtl/acc_drain_requant.sv | 97 +++++++++
 tb/tb_acc_drain_requant.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/acc_drain_requant.sv
// acc_drain_requant: snapshot a MAC row, clear it, stream requantized int8 lanes one per beat.
// Optional ReLU clamp of negative results is enabled by defining ACC_DRAIN_RELU_EN.
module acc_drain_requant #(
  parameter int N_LANES = 8,
  parameter int ACC_W   = 32,
  parameter int MULT_W  = 16,
  parameter int SHIFT_W = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tile_done,
  input  logic [N_LANES*ACC_W-1:0]   acc_in,
  input  logic [N_LANES-1:0]         sat_in,
  input  logic [MULT_W-1:0]          req_mult,
  input  logic [SHIFT_W-1:0]         req_shift,
  output logic                       mac_clr,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_data,
  output logic [$clog2(N_LANES)-1:0] out_lane,
  output logic                       out_last,
  output logic                       out_sat,
  output logic                       overrun,
  input  logic                       overrun_clr
);
  localparam int LW = $clog2(N_LANES);
  localparam int PW = ACC_W + MULT_W + 1;
  localparam logic signed [PW-1:0] MAX_Q = 127;
  localparam logic signed [PW-1:0] MIN_Q = -128;
  typedef enum logic [1:0] {IDLE, CLEAR, DRAIN} state_t;
  state_t state, state_nx;
  logic signed [ACC_W-1:0] acc_snap [N_LANES];
  logic [N_LANES-1:0] sat_snap;
  logic [MULT_W-1:0] mult_snap;
  logic [SHIFT_W-1:0] shift_snap;
  logic [LW-1:0] sel;
  logic signed [PW-1:0] p, rnd, r, rq;
  logic clamp, load, accept;
  logic [7:0] q;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (tile_done) state_nx = CLEAR;
      CLEAR:   state_nx = DRAIN;
      DRAIN:   if (accept && out_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    mac_clr = state == CLEAR;
    busy = state != IDLE;
  end
  // Snapshot is deliberately left out of reset; only a fresh capture replaces it.
  always_ff @(posedge clk)
    if (rst_n && state == IDLE && tile_done) begin
      for (int i = 0; i < N_LANES; i++) acc_snap[i] <= acc_in[i*ACC_W +: ACC_W];
      sat_snap <= sat_in;
      mult_snap <= req_mult;
      shift_snap <= req_shift;
    end
  always_comb begin
    sel = state == CLEAR ? '0 : out_lane + LW'(1);
    p = PW'(acc_snap[sel]) * PW'($signed({1'b0, mult_snap}));
    rnd = shift_snap == '0 ? '0 : PW'(1) << (shift_snap - SHIFT_W'(1));
    r = (p + rnd) >>> shift_snap;
`ifdef ACC_DRAIN_RELU_EN
    rq = r[PW-1] ? '0 : r;
`else
    rq = r;
`endif
    clamp = rq > MAX_Q || rq < MIN_Q;
    q = rq > MAX_Q ? 8'h7f : rq < MIN_Q ? 8'h80 : rq[7:0];
    accept = out_valid && out_ready;
    load = state == CLEAR || (state == DRAIN && (!out_valid || out_ready) && !out_last);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_lane <= '0;
      out_last <= 1'b0;
      out_sat <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data <= q;
      out_lane <= sel;
      out_last <= sel == LW'(N_LANES - 1);
      out_sat <= clamp | sat_snap[sel];
    end else if (accept) out_valid <= 1'b0;
  always_ff @(posedge clk)
    if (!rst_n) overrun <= 1'b0;
    else overrun <= (tile_done && state != IDLE) ? 1'b1 : overrun_clr ? 1'b0 : overrun;
endmodule

// File: tb/tb_acc_drain_requant.sv
// tb_acc_drain_requant: directed and randomized tiles checked against an arithmetic requant model.
module tb_acc_drain_requant;
  localparam int N = 8, AW = 32, MW = 16, SW = 5, LW = 3;
  logic clk = 0, rst_n = 0, tile_done = 0, out_ready = 1, overrun_clr = 0;
  logic [N*AW-1:0] acc_in = '0;
  logic [N-1:0] sat_in = '0;
  logic [MW-1:0] req_mult = '0;
  logic [SW-1:0] req_shift = '0;
  logic mac_clr, busy, out_valid, out_last, out_sat, overrun;
  logic [7:0] out_data;
  logic [LW-1:0] out_lane;
  int errors = 0, checks = 0, mac_clr_cnt = 0;
  logic signed [AW-1:0] a [N];
  logic [N-1:0] s;
  logic [MW-1:0] m;
  logic [SW-1:0] sh;
  logic [7:0] got_data [N];
  logic got_sat [N];

  acc_drain_requant dut (
    .clk(clk), .rst_n(rst_n), .tile_done(tile_done), .acc_in(acc_in), .sat_in(sat_in),
    .req_mult(req_mult), .req_shift(req_shift), .mac_clr(mac_clr), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_lane(out_lane),
    .out_last(out_last), .out_sat(out_sat), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mac_clr) mac_clr_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic signed [AW-1:0] acc, input logic [MW-1:0] mu,
                                input logic [SW-1:0] sa, input logic si,
                                output logic [7:0] d, output logic st);
    longint p, r;
    p = longint'(acc) * longint'(mu);
    r = p;
    if (sa != 0) r = (p + (longint'(1) << (sa - 1))) >>> sa;
`ifdef ACC_DRAIN_RELU_EN
    if (r < 0) r = 0;
`endif
    st = si;
    if (r > 127) begin r = 127; st = 1'b1; end
    else if (r < -128) begin r = -128; st = 1'b1; end
    d = r[7:0];
  endfunction

  // mode 0: always ready, 1: random ready, 2: stall three cycles on lane 2
  task automatic run_tile(input int mode, input int ovr_at, input bit ovr_clr);
    int j, idx, stall, mc0;
    logic [7:0] ed;
    logic es;
    mc0 = mac_clr_cnt;
    for (int i = 0; i < N; i++) acc_in[i*AW +: AW] = a[i];
    sat_in = s;
    req_mult = m;
    req_shift = sh;
    out_ready = 1'b1;
    tile_done = 1'b1;
    tick();
    tile_done = 1'b0;
    check("clear_mac_clr", mac_clr, 1);
    check("clear_busy", busy, 1);
    check("clear_valid", out_valid, 0);
    idx = 0; stall = 0; j = 0;
    while (idx < N && j < 300) begin
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : !(idx == 2 && stall < 3);
      tile_done = j == ovr_at;
      overrun_clr = ovr_clr && j == ovr_at;
      for (int i = 0; i < N; i++) acc_in[i*AW +: AW] = $urandom;
      req_mult = MW'($urandom);
      req_shift = SW'($urandom);
      sat_in = N'($urandom);
      if (mode == 2 && idx == 2 && !out_ready) begin
        stall++;
        model(a[2], m, sh, s[2], ed, es);
        check("hold_valid", out_valid, 1);
        check("hold_lane", out_lane, 2);
        check("hold_data", out_data, ed);
      end
      if (out_valid && out_ready) begin
        model(a[idx], m, sh, s[idx], ed, es);
        check("beat_lane", out_lane, idx);
        check("beat_data", out_data, ed);
        check("beat_sat", out_sat, es);
        check("beat_last", out_last, idx == N - 1);
        if (mode == 0) check("beat_cycle", j, idx + 1);
        got_data[idx] = out_data;
        got_sat[idx] = out_sat;
        idx++;
      end
      tick();
      j++;
    end
    tile_done = 1'b0;
    overrun_clr = 1'b0;
    out_ready = 1'b1;
    check("lanes_delivered", idx, N);
    check("busy_fall", busy, 0);
    check("valid_fall", out_valid, 0);
    check("mac_clr_once", mac_clr_cnt - mc0, 1);
  endtask

  task automatic rand_tile();
    for (int i = 0; i < N; i++)
      a[i] = $urandom_range(0, 3) == 0 ? AW'($urandom) : AW'(int'($urandom_range(0, 40000)) - 20000);
    s = N'($urandom_range(0, 3) == 0 ? $urandom : 0);
    m = MW'($urandom_range(1, 600));
    sh = SW'($urandom_range(0, 31));
  endtask

  initial begin
    int v, mc0;
    tick();
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_mac_clr", mac_clr, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_data", out_data, 0);
    check("rst_lane", out_lane, 0);
    check("rst_last", out_last, 0);
    check("rst_sat", out_sat, 0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < N; i++) a[i] = i;
    s = '0; m = 1; sh = 0;
    run_tile(0, -1, 0);
    for (int i = 0; i < N; i++) check("basic_data", got_data[i], i);
    a = '{5, -5, 4, -4, 3, -3, 1, -1};
    m = 1; sh = 1;
    run_tile(0, -1, 0);
    check("round_pos", got_data[0], 3);
`ifdef ACC_DRAIN_RELU_EN
    check("round_neg", got_data[1], 0);
`else
    check("round_neg", got_data[1], 8'hfe);
`endif
    a = '{1000, -1000, 40, -40, 680, -688, 0, 12345};
    m = 3; sh = 4;
    run_tile(1, -1, 0);
    check("clamp_hi", got_data[0], 127);
    check("clamp_hi_sat", got_sat[0], 1);
`ifdef ACC_DRAIN_RELU_EN
    check("clamp_lo", got_data[1], 0);
    check("clamp_lo_sat", got_sat[1], 0);
`else
    check("clamp_lo", got_data[1], 8'h80);
    check("clamp_lo_sat", got_sat[1], 1);
`endif
    check("in_range", got_data[2], 8);
    check("in_range_sat", got_sat[2], 0);
    for (int i = 0; i < N; i++) a[i] = 10;
    s = 8'b0000_1000; m = 1; sh = 0;
    run_tile(0, -1, 0);
    for (int i = 0; i < N; i++) begin
      check("pass_data", got_data[i], 10);
      check("pass_sat", got_sat[i], i == 3);
    end
    rand_tile();
    run_tile(2, -1, 0);
    check("overrun_idle", overrun, 0);
    rand_tile();
    run_tile(1, 3, 0);
    check("overrun_set", overrun, 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("overrun_clr", overrun, 0);
    rand_tile();
    run_tile(0, 4, 1);
    check("overrun_set_wins", overrun, 1);
    tick();
    check("overrun_sticky", overrun, 1);
    for (int k = 0; k < 6; k++) begin
      rand_tile();
      run_tile(1, -1, 0);
    end
    check("overrun_held", overrun, 1);
    rand_tile();
    for (int i = 0; i < N; i++) acc_in[i*AW +: AW] = a[i];
    tile_done = 1'b1;
    tick();
    tile_done = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    tick();
    tick();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_mac_clr", mac_clr, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_overrun", overrun, 0);
    rst_n = 1'b1;
    mc0 = mac_clr_cnt;
    v = 0;
    repeat (12) begin
      tick();
      v += int'(out_valid) + int'(busy);
    end
    check("post_rst_quiet", v, 0);
    check("post_rst_no_clr", mac_clr_cnt - mc0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
